tdmi: RTL and testbench



---
 rtl/tdmi_pkg.sv | 19 +
 rtl/tdmi_sync_edge.sv | 32 +++
 rtl/tdmi.sv | 178 +++++++++++++++++
 tb/tb_tdmi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tdmi_pkg.sv
// Shared constants for the TDM receive interface: register map, field widths
// and receiver state encoding.
package tdmi_pkg;

  localparam int CH_W     = 5;
  localparam int SAMPLE_W = 8;

  localparam logic [15:0] TDMI_ALL     = 16'h0000;
  localparam logic [15:0] TDMI_DATA    = 16'h0004;
  localparam logic [15:0] TDMI_CHANNEL = 16'h0008;
  localparam logic [15:0] TDMI_START   = 16'h000C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOCK
  } rx_state_e;

endpackage

// File: rtl/tdmi_sync_edge.sv
// Two-flop synchronizer for a slow asynchronous level, with single-cycle
// rise and fall strobes derived from the synchronized value.
module tdmi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/tdmi.sv
// Serial TDM receiver (32 ch x 8 bit, MSB first) with a Wishbone register view.
// Optional macro TDMI_RESYNC_EN: every frame_sync rising edge realigns the framer.
module tdmi
  import tdmi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_clk,
  input  logic        frame_sync,
  input  logic        data_in,
  output logic        new_data_int,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  rx_state_e             state_q, state_d;
  logic                  ser_sync, ser_rise, ser_fall;
  logic                  fs_sync, fs_rise, fs_fall;
  logic                  data_meta, data_sync;
  logic                  fs_prev, fs_edge, align, strobe;
  logic [SAMPLE_W-2:0]   shift_q;
  logic [2:0]            bit_cnt;
  logic [CH_W-1:0]       rx_ch, chan_q;
  logic [SAMPLE_W-1:0]   data_q;
  logic                  wb_req, wb_busy, wb_hit, start_wr, enable;
  logic [15:0]           adr;
  logic [31:0]           rd_mux;
  logic                  unused_ok;

  tdmi_sync_edge u_ser_sync (
    .clk  (clk),
    .reset(reset),
    .din  (ser_clk),
    .sync (ser_sync),
    .rise (ser_rise),
    .fall (ser_fall)
  );

  tdmi_sync_edge u_fs_sync (
    .clk  (clk),
    .reset(reset),
    .din  (frame_sync),
    .sync (fs_sync),
    .rise (fs_rise),
    .fall (fs_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      data_meta <= data_in;
      data_sync <= data_meta;
    end
  end

  // frame_sync is judged at bit strobes, not at its own synchronized edge
  assign strobe  = ser_fall;
  assign fs_edge = strobe & fs_sync & ~fs_prev;
`ifdef TDMI_RESYNC_EN
  assign align   = fs_edge & (state_q != ST_IDLE);
`else
  assign align   = fs_edge & (state_q == ST_HUNT);
`endif

  assign adr      = i_wb_adr[15:0];
  assign wb_req   = i_wb_cyc & i_wb_stb;
  assign wb_hit   = wb_req & ~wb_busy;
  assign start_wr = wb_hit & i_wb_we & (adr == TDMI_START);
  assign enable   = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_wr && i_wb_dat[0]) state_d = ST_HUNT;
      ST_HUNT: if (align) state_d = ST_LOCK;
      ST_LOCK: state_d = ST_LOCK;
      default: state_d = ST_IDLE;
    endcase
    if (start_wr && !i_wb_dat[0]) state_d = ST_IDLE;
  end

  // An alignment strobe samples bit 7 of channel 0, so the counter resumes at 6
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_prev      <= 1'b0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      rx_ch        <= '0;
      data_q       <= '0;
      chan_q       <= '0;
      new_data_int <= 1'b0;
    end else begin
      new_data_int <= 1'b0;
      if (strobe) fs_prev <= fs_sync;
      if (state_q == ST_IDLE) begin
        bit_cnt <= '0;
        rx_ch   <= '0;
      end else if (align) begin
        shift_q <= {shift_q[SAMPLE_W-3:0], data_sync};
        bit_cnt <= 3'd6;
        rx_ch   <= '0;
      end else if (strobe && state_q == ST_LOCK) begin
        shift_q <= {shift_q[SAMPLE_W-3:0], data_sync};
        if (bit_cnt == 3'd0) begin
          data_q       <= {shift_q, data_sync};
          chan_q       <= rx_ch;
          new_data_int <= 1'b1;
          rx_ch        <= rx_ch + 5'd1;
          bit_cnt      <= 3'd7;
        end else begin
          bit_cnt <= bit_cnt - 3'd1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (adr)
      TDMI_ALL:     rd_mux = {19'b0, chan_q, data_q};
      TDMI_DATA:    rd_mux = {24'b0, data_q};
      TDMI_CHANNEL: rd_mux = {27'b0, chan_q};
      TDMI_START:   rd_mux = {31'b0, enable};
      default:      rd_mux = '0;
    endcase
  end

  // One ack per strobe assertion; a held strobe must drop before the next access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_busy  <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      wb_busy  <= wb_req;
      o_wb_ack <= wb_hit;
      o_wb_dat <= (wb_hit && !i_wb_we) ? rd_mux : '0;
    end
  end

  assign o_wb_err  = 1'b0;
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign unused_ok = ^{ser_sync, ser_rise, fs_rise, fs_fall, i_wb_sel, i_wb_adr[31:16],
                       i_wb_dat[31:1], scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                       scan_enable, test_mode};

endmodule

// File: tb/tb_tdmi.sv
// Directed self-checking bench for tdmi: framing, register reads, channel wrap,
// frame_sync realignment (both builds of TDMI_RESYNC_EN) and reset behaviour.
module tb_tdmi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ser_clk = 1'b0;
  logic        frame_sync = 1'b0;
  logic        data_in = 1'b0;
  logic        new_data_int;
  logic [31:0] i_wb_adr = '0;
  logic [3:0]  i_wb_sel = 4'hF;
  logic        i_wb_we = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic [31:0] o_wb_dat;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int vectorCount = 0;
  int errorCount  = 0;
  int intCount    = 0;
  int lastIntPos  = 0;

  always #5 clk = ~clk;

  tdmi dut (
    .clk         (clk),
    .reset       (reset),
    .ser_clk     (ser_clk),
    .frame_sync  (frame_sync),
    .data_in     (data_in),
    .new_data_int(new_data_int),
    .i_wb_adr    (i_wb_adr),
    .i_wb_sel    (i_wb_sel),
    .i_wb_we     (i_wb_we),
    .i_wb_dat    (i_wb_dat),
    .o_wb_dat    (o_wb_dat),
    .i_wb_cyc    (i_wb_cyc),
    .i_wb_stb    (i_wb_stb),
    .o_wb_ack    (o_wb_ack),
    .o_wb_err    (o_wb_err),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  always @(posedge clk) if (new_data_int) intCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One serial bit: 10 clk high, 10 clk low; records where new_data_int showed up
  task automatic sendBit(input logic fs, input logic b);
    @(negedge clk);
    ser_clk = 1'b1; data_in = b; frame_sync = fs;
    repeat (9) @(negedge clk);
    @(negedge clk);
    ser_clk = 1'b0;
    lastIntPos = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (new_data_int) lastIntPos = i;
    end
  endtask

  task automatic applyStimulus(input logic fsFirst, input logic [7:0] value);
    for (int i = 7; i >= 0; i--) sendBit(fsFirst && (i == 7), value[i]);
  endtask

  task automatic wbRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    i_wb_adr = addr; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    checkOutput("rd_ack", 32'(o_wb_ack), 32'd1);
    data = o_wb_dat;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    i_wb_adr = addr; i_wb_dat = data; i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    checkOutput("wr_ack", 32'(o_wb_ack), 32'd1);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          base;
    int          ackSeen;

    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {26'b0, new_data_int, o_wb_ack, o_wb_err, scan_out0,
                scan_out1, scan_out2 | scan_out3 | scan_out4}, 32'd0);
    checkOutput("rst_dat", o_wb_dat, 32'd0);
    @(negedge clk); reset = 1'b1;
    wbRead(32'h000C, rd); checkOutput("enable_at_rst", rd, 32'd0);
    wbRead(32'h0000, rd); checkOutput("all_at_rst", rd, 32'd0);

    // Receiver disabled: two full frames must raise no interrupt
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 32; c++) applyStimulus(c == 0, 8'(c * 7 + 1));
    checkOutput("idle_ints", 32'(intCount), 32'd0);

    wbWrite(32'h000C, 32'd1);
    wbRead(32'h000C, rd); checkOutput("enable_set", rd, 32'd1);

    base = intCount;
    applyStimulus(1'b1, 8'hA5);
    checkOutput("int_latency", 32'(lastIntPos), 32'd3);
    checkOutput("ch0_ints", 32'(intCount - base), 32'd1);
    wbRead(32'h0000, rd); checkOutput("ch0_all", rd, 32'h0000_00A5);

    for (int c = 1; c < 32; c++) begin
      b = (c == 17) ? 8'h3C : 8'($urandom);
      applyStimulus(1'b0, b);
      wbRead(32'h0004, rd); checkOutput($sformatf("data_ch%0d", c), rd, {24'b0, b});
      wbRead(32'h0008, rd); checkOutput($sformatf("chan_ch%0d", c), rd, 32'(c));
      if (c == 17) begin
        wbRead(32'h0000, rd); checkOutput("all_ch17", rd, 32'h0000_113C);
      end
    end

    // Next frame without frame_sync: channel wraps to 0
    applyStimulus(1'b0, 8'h5A);
    wbRead(32'h0008, rd); checkOutput("wrap_chan", rd, 32'd0);
    wbRead(32'h0004, rd); checkOutput("wrap_data", rd, 32'h5A);
    checkOutput("frame_ints", 32'(intCount - base), 32'd33);

    for (int c = 1; c <= 8; c++) applyStimulus(1'b0, 8'(c));
    base = intCount;
    sendBit(1'b0, 1'b1); sendBit(1'b0, 1'b0); sendBit(1'b0, 1'b1);
    checkOutput("partial_ints", 32'(intCount - base), 32'd0);
    applyStimulus(1'b1, 8'hC3);
    checkOutput("resync_ints", 32'(intCount - base), 32'd1);
`ifdef TDMI_RESYNC_EN
    wbRead(32'h0000, rd); checkOutput("resync_all", rd, 32'h0000_00C3);
`else
    wbRead(32'h0000, rd); checkOutput("resync_all", rd, 32'h0000_09B8);
`endif
    for (int i = 0; i < 5; i++) sendBit(1'b0, 1'b0);
`ifdef TDMI_RESYNC_EN
    checkOutput("tail_ints", 32'(intCount - base), 32'd1);
    wbRead(32'h0000, rd); checkOutput("tail_all", rd, 32'h0000_00C3);
`else
    checkOutput("tail_ints", 32'(intCount - base), 32'd2);
    wbRead(32'h0000, rd); checkOutput("tail_all", rd, 32'h0000_0A60);
`endif

    wbWrite(32'h0004, 32'hFF);
    wbRead(32'h0000, rd);
`ifdef TDMI_RESYNC_EN
    checkOutput("write_ignored", rd, 32'h0000_00C3);
`else
    checkOutput("write_ignored", rd, 32'h0000_0A60);
`endif
    wbRead(32'h0010, rd); checkOutput("unmapped", rd, 32'd0);

    @(negedge clk);
    i_wb_adr = 32'h0008; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    ackSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_wb_ack) ackSeen++;
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    checkOutput("ack_once", 32'(ackSeen), 32'd1);

    // Stop clears lock; after restart nothing arrives until a frame_sync edge
    wbWrite(32'h000C, 32'd0);
    wbRead(32'h000C, rd); checkOutput("enable_clr", rd, 32'd0);
    wbWrite(32'h000C, 32'd1);
    base = intCount;
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22);
    checkOutput("relock_ints", 32'(intCount - base), 32'd0);

    for (int i = 0; i < 4; i++) sendBit(i == 0, 1'b1);
    @(negedge clk);
    i_wb_adr = 32'h000C; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    checkOutput("pre_rst_dat", o_wb_dat, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_dat", o_wb_dat, 32'd0);
    checkOutput("mid_rst_ack", 32'(o_wb_ack), 32'd0);
    checkOutput("mid_rst_int", 32'(new_data_int), 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge clk); reset = 1'b1;
    wbRead(32'h000C, rd); checkOutput("post_rst_enable", rd, 32'd0);
    wbRead(32'h0000, rd); checkOutput("post_rst_all", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
